// File: rtl/data_sync_tx.sv
// Source-domain launcher for a multi-bit CDC: holds a word on a stable bus and runs a four-phase
// req/ack handshake against a synchronized acknowledge. Optional skid buffer: `DATA_SYNC_TX_SKID_EN.
module data_sync_tx #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [BUS_WIDTH-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    input  logic                 i_ack_async,
    output logic [BUS_WIDTH-1:0] o_sync_bus,
    output logic                 o_bus_enable,
    output logic                 o_busy,
    output logic                 o_tx_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [NUM_STAGES-1:0] r_ack_chain;
    logic                  w_ack_sync;
    logic                  r_out_of_reset;
    logic [BUS_WIDTH-1:0]  r_sync_bus;
    logic                  r_bus_enable;
    logic                  r_tx_done;
    logic                  w_tx_ready;
    logic                  w_accept;
    logic                  w_load_direct;
    logic                  w_done_next;

`ifdef DATA_SYNC_TX_SKID_EN
    logic                  r_hold_full;
    logic [BUS_WIDTH-1:0]  r_hold_data;
    logic                  w_fill_hold;
    logic                  w_drain_hold;
`endif

    assign w_ack_sync = r_ack_chain[NUM_STAGES-1];

    // A stale acknowledge seen in IDLE blocks new words until the destination lets go.
`ifdef DATA_SYNC_TX_SKID_EN
    assign w_tx_ready = r_out_of_reset && !r_hold_full && !((r_state == ST_IDLE) && w_ack_sync);
`else
    assign w_tx_ready = r_out_of_reset && (r_state == ST_IDLE) && !w_ack_sync;
`endif

    assign w_accept     = i_tx_valid && w_tx_ready;
    assign o_tx_ready   = w_tx_ready;
    assign o_sync_bus   = r_sync_bus;
    assign o_bus_enable = r_bus_enable;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_tx_done    = r_tx_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack_chain    <= '0;
            r_out_of_reset <= 1'b0;
        end else begin
            r_ack_chain    <= {r_ack_chain[NUM_STAGES-2:0], i_ack_async};
            r_out_of_reset <= 1'b1;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_direct = 1'b0;
        w_done_next   = 1'b0;
`ifdef DATA_SYNC_TX_SKID_EN
        w_fill_hold   = 1'b0;
        w_drain_hold  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next  = ST_REQ;
                    w_load_direct = 1'b1;
                end
            end
            ST_REQ: begin
                if (w_ack_sync) begin
                    w_state_next = ST_RELEASE;
                end
`ifdef DATA_SYNC_TX_SKID_EN
                w_fill_hold = w_accept;
`endif
            end
            ST_RELEASE: begin
                if (!w_ack_sync) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
`ifdef DATA_SYNC_TX_SKID_EN
                    // A word accepted on the exit edge itself goes straight onto the bus.
                    if (r_hold_full) begin
                        w_state_next = ST_REQ;
                        w_drain_hold = 1'b1;
                    end else if (w_accept) begin
                        w_state_next  = ST_REQ;
                        w_load_direct = 1'b1;
                    end
`endif
                end
`ifdef DATA_SYNC_TX_SKID_EN
                else begin
                    w_fill_hold = w_accept;
                end
`endif
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Bus and request only change together on REQ entry, so the bus is stable while enable is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_sync_bus   <= '0;
            r_bus_enable <= 1'b0;
            r_tx_done    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_bus_enable <= (w_state_next == ST_REQ);
            r_tx_done    <= w_done_next;
            if (w_load_direct) begin
                r_sync_bus <= i_tx_data;
`ifdef DATA_SYNC_TX_SKID_EN
            end else if (w_drain_hold) begin
                r_sync_bus <= r_hold_data;
`endif
            end
        end
    end

`ifdef DATA_SYNC_TX_SKID_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else if (w_fill_hold) begin
            r_hold_full <= 1'b1;
            r_hold_data <= i_tx_data;
        end else if (w_drain_hold) begin
            r_hold_full <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/data_sync_tx.md
# data_sync_tx

Source-domain launcher for the multi-bit data synchronizer. It captures a parallel word and drives it on a stable bus. It raises a level `bus_enable` for the destination-side synchronizer and pulse generator to sample. It runs a four-phase req/ack handshake, with the destination's acknowledge brought back through an internal multi-flop synchronizer. It sits in the sending clock domain, opposite the destination enable-synchronizer/pulse-generator stage.

## Interface
- `BUS_WIDTH`, default 8: width of the data word.
- `NUM_STAGES`, default 2: flop stages in the ack synchronizer, minimum 2.
- `CLK`  in  1  source-domain clock.
- `RST`  in  1  asynchronous, active-low reset.
- `tx_data`  in  BUS_WIDTH  word to transfer, sampled on accept.
- `tx_valid`  in  1  word available.
- `tx_ready`  out  1  block can accept a word; the word is accepted when `tx_valid && tx_ready` at a rising `CLK`.
- `ack_async`  in  1  level acknowledge from the destination domain, unsynchronized.
- `sync_bus`  out  BUS_WIDTH  registered data bus crossing to the destination.
- `bus_enable`  out  1  registered level request crossing to the destination.
- `busy`  out  1  handshake in progress, meaning state is not IDLE.
- `tx_done`  out  1  one-cycle pulse when a transfer's handshake completes.

## Operation
- The ack synchronizer is a `NUM_STAGES`-deep flop chain on `ack_async`; the last stage is `ack_sync`. Only `ack_sync` is used in logic.
- FSM states and transitions:
  - IDLE: `bus_enable`=0. On accept, load `sync_bus`<=`tx_data` and go to REQ.
  - REQ: `bus_enable`=1. When `ack_sync`=1, go to RELEASE.
  - RELEASE: `bus_enable`=0. When `ack_sync`=0, assert `tx_done` and go to IDLE (or to REQ under skid, see Configuration).
- `sync_bus` changes only on the cycle `bus_enable` rises. It holds from REQ entry until the next load, so it is stable across the whole handshake.
- `tx_ready` without the macro is `(state==IDLE)`.
- If `ack_sync`=1 while in IDLE (destination stale after a partial reset), the block stays in IDLE and `tx_ready` is forced to 0 until `ack_sync`=0.
- Reset value of every output: `sync_bus`=0, `bus_enable`=0, `busy`=0, `tx_done`=0, `tx_ready`=0 during reset and 1 from the first clock after release.
- The ack synchronizer flops and the FSM reset to 0/IDLE.
- Reset mid-transfer aborts the transfer: the word is lost and `tx_done` is not pulsed.

## Timing
- Accept at edge N: `bus_enable`=1 and `sync_bus` valid after edge N.
- `ack_async` rising lands on `ack_sync` after `NUM_STAGES` edges. `bus_enable` falls on the edge after `ack_sync` is seen high.
- `ack_async` falling likewise takes `NUM_STAGES` edges. `tx_done` is high for exactly one cycle, registered, on the edge where RELEASE exits.
- Minimum source-side cycles per transfer is 2×`NUM_STAGES`+3, plus destination latency.

## Configuration
- Macro: `DATA_SYNC_TX_SKID_EN`.
- Defined: adds a one-entry holding register.
  - `tx_ready` = holding register empty.
  - An accept in IDLE loads `sync_bus` directly and the holding register stays empty.
  - An accept in REQ/RELEASE fills the holding register.
  - On RELEASE exit with the holding register full: pulse `tx_done`, load `sync_bus` from the holding register, raise `bus_enable`, go straight to REQ, and empty the holding register, all on the same edge.
  - Reset clears the holding register.
- Undefined: no holding register; behaviour is exactly as in Operation.

## Test plan
- Reset: assert `RST`=0 mid-REQ with `sync_bus`=0xA5 → all outputs 0 immediately; IDLE and `tx_ready`=1 one edge after release.
- Single transfer (`NUM_STAGES`=2, `BUS_WIDTH`=8): accept 0x3C, model the destination acking 1 cycle after seeing `bus_enable` and releasing 1 cycle after it drops.
  - `sync_bus`=0x3C stable throughout; `bus_enable` high until 2 edges after ack rises.
  - `tx_done` pulses once.
- Back-to-back without the macro: hold `tx_valid` with 0x11 then 0x22 → second accept only after `tx_done`; `sync_bus` never changes while `bus_enable`=1.
- Skid (macro defined): offer 0x22 during REQ of 0x11 → `tx_ready` drops; on the `tx_done` edge `bus_enable` re-rises with `sync_bus`=0x22 and `tx_ready` returns to 1.
- Stale ack: hold `ack_async`=1 after reset → `tx_ready`=0 and no transfer starts; drop `ack_async` → `tx_ready`=1 after 2 edges.
- Glitch-free request: randomize ack latency 0–10 destination cycles over 200 words → `bus_enable` toggles exactly twice per word, the received sequence matches the sent sequence, and the `tx_done` count is 200.
